// File: rtl/cla_addsub_pipe_if.sv
// Streaming operand/result bundle for cla_addsub_pipe: an input beat channel
// (operands, mode, carry) and an output beat channel (result and status flags).
interface cla_addsub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, neg
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, neg
    );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready streaming.
// Stage 1 forms bit and 4-bit group generate/propagate; stage 2 resolves carries and flags.
module cla_addsub_pipe #(
    parameter int WIDTH = 16
) (
    input logic              clk,
    input logic              rst,
    cla_addsub_pipe_if.slave bus
);
    localparam int NG = WIDTH / 4;
    localparam int NS = (NG + 3) / 4;

    // Group generate/propagate of four adjacent (g, p) pairs.
    function automatic logic [1:0] group_gp(input logic [3:0] g, input logic [3:0] p);
        logic gg;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {gg, &p};
    endfunction

    // Flat 4-way lookahead: returns {c4, c3, c2, c1, c0} from (g, p) and carry-in.
    function automatic logic [4:0] lookahead4(input logic [3:0] g, input logic [3:0] p,
                                              input logic c);
        logic [4:0] cy;
        cy[0] = c;
        cy[1] = g[0] | (p[0] & c);
        cy[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        cy[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        cy[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c);
        return cy;
    endfunction

    // ---------------------------------------------------------------- handshake
    logic s1_valid;
    logic adv2;
    logic accept;

    assign adv2         = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || adv2;
    assign accept       = bus.in_valid && bus.in_ready;

    // ---------------------------------------------------------------- stage 1
    logic [WIDTH-1:0] bp_d;
    logic             c0_d;
    logic [WIDTH-1:0] g_d;
    logic [WIDTH-1:0] p_d;
    logic [NG-1:0]    gg_d;
    logic [NG-1:0]    pg_d;

    // NOTE: every always_comb output gets a default before any conditional
    // or loop assignment, so no path can leave it unassigned and infer a latch.
    always_comb begin
        gg_d = '0;
        pg_d = '0;
        bp_d = bus.sub ? ~bus.b : bus.b;
        c0_d = bus.sub ? ~bus.cin : bus.cin;
        g_d  = bus.a & bp_d;
        p_d  = bus.a ^ bp_d;
        for (int k = 0; k < NG; k++) begin
            {gg_d[k], pg_d[k]} = group_gp(g_d[4*k +: 4], p_d[4*k +: 4]);
        end
    end

    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_bp;
    logic             s1_c0;
    logic [WIDTH-1:0] s1_g;
    logic [WIDTH-1:0] s1_p;
    logic [NG-1:0]    s1_gg;
    logic [NG-1:0]    s1_pg;

    // NOTE: state is written with non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    // NOTE: the data registers are reset too, not just the valid bits: the
    // cleared pipeline must present an all-zero result, not stale operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_bp    <= '0;
            s1_c0    <= 1'b0;
            s1_g     <= '0;
            s1_p     <= '0;
            s1_gg    <= '0;
            s1_pg    <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= bus.a;
                s1_bp    <= bp_d;
                s1_c0    <= c0_d;
                s1_g     <= g_d;
                s1_p     <= p_d;
                s1_gg    <= gg_d;
                s1_pg    <= pg_d;
            end else if (adv2) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- stage 2
    // Groups are padded to whole supergroups with g = 0, p = 1 so the padding is
    // transparent to carries; the supergroup lookahead then feeds each group's.
    logic [4*NS-1:0]  gg_pad;
    logic [4*NS-1:0]  pg_pad;
    logic [3:0]       sg;
    logic [3:0]       sp;
    logic [4:0]       sc;
    logic [4*NS:0]    gc;
    logic [WIDTH:0]   bc;

    always_comb begin
        gg_pad         = '0;
        pg_pad         = '1;
        gg_pad[NG-1:0] = s1_gg;
        pg_pad[NG-1:0] = s1_pg;
        sg             = '0;
        sp             = '1;
        for (int j = 0; j < NS; j++) begin
            {sg[j], sp[j]} = group_gp(gg_pad[4*j +: 4], pg_pad[4*j +: 4]);
        end
        sc = lookahead4(sg, sp, s1_c0);
        gc = '0;
        for (int j = 0; j < NS; j++) begin
            gc[4*j +: 5] = lookahead4(gg_pad[4*j +: 4], pg_pad[4*j +: 4], sc[j]);
        end
        bc = '0;
        for (int k = 0; k < NG; k++) begin
            bc[4*k +: 5] = lookahead4(s1_g[4*k +: 4], s1_p[4*k +: 4], gc[k]);
        end
    end

    // Carries above group NG and the in-group copy of the carry-out drive nothing.
    logic lookahead_unused;
    assign lookahead_unused = ^{sc, gc, bc};

    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             zero_d;
    logic             neg_d;

    assign sum_d  = s1_p ^ bc[WIDTH-1:0];
    assign cout_d = gc[NG];
    // Like-signed effective operands producing a result of the other sign.
    assign ovf_d  = (s1_a[WIDTH-1] ~^ s1_bp[WIDTH-1]) & (s1_a[WIDTH-1] ^ sum_d[WIDTH-1]);
    assign neg_d  = sum_d[WIDTH-1];
    // The sum is zero exactly when each carry equals that bit's propagate, and
    // that carry is then a|b' of the bit below: detectable without the carry tree.
    assign zero_d = (s1_p == {s1_a[WIDTH-2:0] | s1_bp[WIDTH-2:0], s1_c0});

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.sum       <= '0;
            bus.cout      <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.zero      <= 1'b0;
            bus.neg       <= 1'b0;
        end else if (adv2) begin
            bus.out_valid <= s1_valid;
            bus.sum       <= sum_d;
            bus.cout      <= cout_d;
            bus.ovf       <= ovf_d;
            bus.zero      <= zero_d;
            bus.neg       <= neg_d;
        end
    end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe at WIDTH = 4, 16 and 64: directed vectors,
// back-pressure and mid-stream reset sequences, and random streams against an arithmetic model.
module tb_cla_addsub_pipe;
    localparam int NBEATS = 4000;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } res_t;

    typedef struct {
        int          wsel;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        res_t        r;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        drv_valid, drv_cin, drv_sub, drv_ready;
    logic [63:0] drv_a, drv_b;
    int          sel;

    cla_addsub_pipe_if #(.WIDTH(4))  bus4 ();
    cla_addsub_pipe_if #(.WIDTH(16)) bus16 ();
    cla_addsub_pipe_if #(.WIDTH(64)) bus64 ();

    assign bus4.in_valid   = drv_valid && (sel == 0);
    assign bus4.a          = drv_a[3:0];
    assign bus4.b          = drv_b[3:0];
    assign bus4.cin        = drv_cin;
    assign bus4.sub        = drv_sub;
    assign bus4.out_ready  = drv_ready && (sel == 0);
    assign bus16.in_valid  = drv_valid && (sel == 1);
    assign bus16.a         = drv_a[15:0];
    assign bus16.b         = drv_b[15:0];
    assign bus16.cin       = drv_cin;
    assign bus16.sub       = drv_sub;
    assign bus16.out_ready = drv_ready && (sel == 1);
    assign bus64.in_valid  = drv_valid && (sel == 2);
    assign bus64.a         = drv_a;
    assign bus64.b         = drv_b;
    assign bus64.cin       = drv_cin;
    assign bus64.sub       = drv_sub;
    assign bus64.out_ready = drv_ready && (sel == 2);

    cla_addsub_pipe #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
    cla_addsub_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    cla_addsub_pipe #(.WIDTH(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

    logic        mon_in_ready, mon_out_valid, mon_cout, mon_ovf, mon_zero, mon_neg;
    logic [63:0] mon_sum;

    always_comb begin
        mon_in_ready  = 1'b0;
        mon_out_valid = 1'b0;
        mon_sum       = '0;
        mon_cout      = 1'b0;
        mon_ovf       = 1'b0;
        mon_zero      = 1'b0;
        mon_neg       = 1'b0;
        case (sel)
            0: begin
                mon_in_ready = bus4.in_ready;  mon_out_valid = bus4.out_valid;
                mon_sum = 64'(bus4.sum);       mon_cout = bus4.cout;
                mon_ovf = bus4.ovf;            mon_zero = bus4.zero;  mon_neg = bus4.neg;
            end
            1: begin
                mon_in_ready = bus16.in_ready; mon_out_valid = bus16.out_valid;
                mon_sum = 64'(bus16.sum);      mon_cout = bus16.cout;
                mon_ovf = bus16.ovf;           mon_zero = bus16.zero; mon_neg = bus16.neg;
            end
            default: begin
                mon_in_ready = bus64.in_ready; mon_out_valid = bus64.out_valid;
                mon_sum = bus64.sum;           mon_cout = bus64.cout;
                mon_ovf = bus64.ovf;           mon_zero = bus64.zero; mon_neg = bus64.neg;
            end
        endcase
    end

    int   n_cmp = 0;
    int   n_bad = 0;
    res_t exp_q[$];
    logic last_acc, last_xfer;

    function automatic int width_of(input int s);
        return (s == 0) ? 4 : (s == 1) ? 16 : 64;
    endfunction

    // Plain signed/unsigned arithmetic on wide integers, not a carry network.
    function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub);
        res_t               r;
        logic [63:0]        m;
        logic signed [69:0] pw, half, ua, ub, uc, ur, sa, sb, sr, mv;
        m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        pw   = 70'sd1 <<< w;
        half = pw >>> 1;
        ua   = $signed({6'd0, a & m});
        ub   = $signed({6'd0, b & m});
        uc   = cin ? 70'sd1 : 70'sd0;
        ur   = sub ? (ua - ub - uc) : (ua + ub + uc);
        sa   = a[w-1] ? (ua - pw) : ua;
        sb   = b[w-1] ? (ub - pw) : ub;
        sr   = sub ? (sa - sb - uc) : (sa + sb + uc);
        mv   = ur & (pw - 70'sd1);
        r.sum  = mv[63:0];
        r.cout = sub ? (ur >= 0) : (ur >= pw);
        r.ovf  = (sr >= half) || (sr < -half);
        r.zero = (r.sum == 64'd0);
        r.neg  = r.sum[w-1];
        return r;
    endfunction

    function automatic vec_t mk(input int ws, input logic [63:0] a, input logic [63:0] b,
                                input logic cin, input logic sub, input logic [63:0] s,
                                input logic co, input logic ov, input logic z, input logic n);
        vec_t v;
        v.wsel = ws; v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.r.sum = s; v.r.cout = co; v.r.ovf = ov; v.r.zero = z; v.r.neg = n;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cmp_res(input string tag, input res_t e);
        check({tag, "_sum"},  mon_sum,  e.sum);
        check({tag, "_cout"}, mon_cout, 64'(e.cout));
        check({tag, "_ovf"},  mon_ovf,  64'(e.ovf));
        check({tag, "_zero"}, mon_zero, 64'(e.zero));
        check({tag, "_neg"},  mon_neg,  64'(e.neg));
    endtask

    // One clock of stimulus; scores handshake and any presented result before the next edge.
    task automatic step(input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub, input logic rdy);
        int occ;
        @(negedge clk);
        drv_valid = v; drv_a = a; drv_b = b; drv_cin = cin; drv_sub = sub; drv_ready = rdy;
        #1;
        occ = exp_q.size();
        check("in_ready", mon_in_ready, 64'((occ < 2) || rdy));
        if (occ == 2) check("full_out_valid", mon_out_valid, 1);
        last_acc  = v && mon_in_ready;
        last_xfer = mon_out_valid && rdy;
        if (mon_out_valid) begin
            if (occ == 0) begin
                check("spurious_out_valid", mon_out_valid, 0);
            end else begin
                cmp_res("stream", exp_q[0]);
                if (last_xfer) void'(exp_q.pop_front());
            end
        end
        if (last_acc) exp_q.push_back(model(width_of(sel), a, b, cin, sub));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            n++;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 0);
    endtask

    initial begin
        #950_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    vec_t        vt[15];
    logic [63:0] ba[4];
    logic [63:0] bb[4];

    initial begin
        int idx, nx;
        rst = 1'b1; sel = 1;
        drv_valid = 0; drv_a = '0; drv_b = '0; drv_cin = 0; drv_sub = 0; drv_ready = 0;

        vt[0]  = mk(1, 64'hFFFF, 64'h0001, 0, 0, 64'h0000, 1, 0, 1, 0);
        vt[1]  = mk(1, 64'h7FFF, 64'h0001, 1, 0, 64'h8001, 0, 1, 0, 1);
        vt[2]  = mk(1, 64'h8000, 64'h0001, 0, 1, 64'h7FFF, 1, 1, 0, 0);
        vt[3]  = mk(1, 64'h0005, 64'h0007, 0, 1, 64'hFFFE, 0, 0, 0, 1);
        vt[4]  = mk(1, 64'h0005, 64'h0005, 1, 1, 64'hFFFF, 0, 0, 0, 1);
        vt[5]  = mk(1, 64'h0005, 64'h0005, 0, 1, 64'h0000, 1, 0, 1, 0);
        vt[6]  = mk(1, 64'h1234, 64'h4321, 0, 0, 64'h5555, 0, 0, 0, 0);
        vt[7]  = mk(0, 64'h7, 64'h1, 0, 0, 64'h8, 0, 1, 0, 1);
        vt[8]  = mk(0, 64'hF, 64'hF, 1, 0, 64'hF, 1, 0, 0, 1);
        vt[9]  = mk(0, 64'h0, 64'h0, 1, 1, 64'hF, 0, 0, 0, 1);
        vt[10] = mk(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 64'h0, 1, 0, 1, 0);
        vt[11] = mk(2, 64'h8000_0000_0000_0000, 64'h1, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0, 0);
        vt[12] = mk(2, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 0, 0,
                    64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1);
        vt[13] = mk(2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 1, 64'h0, 1, 0, 1, 0);
        vt[14] = mk(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0,
                    64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0, 1);

        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state of every instance, sampled before the next edge.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_out_valid", mon_out_valid, 0);
            check("rst_sum",       mon_sum, 0);
            check("rst_flags",     {mon_cout, mon_ovf, mon_zero, mon_neg}, 0);
            check("rst_in_ready",  mon_in_ready, 1);
        end

        // Directed vectors, one isolated beat each, with exact latency.
        for (int i = 0; i < 15; i++) begin
            sel = vt[i].wsel;
            @(negedge clk);
            drv_valid = 1; drv_a = vt[i].a; drv_b = vt[i].b;
            drv_cin = vt[i].cin; drv_sub = vt[i].sub; drv_ready = 1;
            #1;
            check($sformatf("vec%0d_in_ready", i), mon_in_ready, 1);
            @(negedge clk);
            drv_valid = 0;
            #1;
            check($sformatf("vec%0d_early_valid", i), mon_out_valid, 0);
            @(negedge clk);
            #1;
            check($sformatf("vec%0d_out_valid", i), mon_out_valid, 1);
            cmp_res($sformatf("vec%0d", i), vt[i].r);
            @(negedge clk);
        end

        // Back-pressure: four back-to-back beats against a stalled consumer.
        sel = 1;
        for (int i = 0; i < 4; i++) begin
            ba[i] = 64'($urandom);
            bb[i] = 64'($urandom);
        end
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, ba[idx], bb[idx], idx[0], idx[1], 1'b0);
            if (last_acc) idx++;
        end
        check("bp_accepts", 64'(idx), 2);
        check("bp_in_ready_low", mon_in_ready, 0);
        nx = 0;
        for (int c = 0; c < 4; c++) begin
            step(idx < 4, (idx < 4) ? ba[idx % 4] : 64'd0, (idx < 4) ? bb[idx % 4] : 64'd0,
                 idx[0], idx[1], 1'b1);
            if (last_acc) idx++;
            if (last_xfer) nx++;
        end
        check("bp_release_xfers", 64'(nx), 4);
        check("bp_all_accepted", 64'(idx), 4);
        drain("bp");

        // Reset with two beats in flight, and a beat offered during the reset cycle.
        step(1'b1, 64'h1111, 64'h2222, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h3333, 64'h4444, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1; drv_valid = 1; drv_a = 64'h5555; drv_b = 64'h6666; drv_ready = 1;
        @(negedge clk);
        rst = 1'b0; drv_valid = 0; drv_ready = 0;
        #1;
        exp_q.delete();
        check("midrst_out_valid", mon_out_valid, 0);
        check("midrst_sum",       mon_sum, 0);
        check("midrst_zero",      mon_zero, 0);
        check("midrst_in_ready",  mon_in_ready, 1);
        repeat (4) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'hABCD, 64'h1234, 1'b1, 1'b0, 1'b1);
        check("midrst_accept", last_acc, 1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("midrst_lat_early", mon_out_valid, 0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("midrst_lat_valid", mon_out_valid, 1);
        drain("midrst");

        // Randomised streams with random valid and bursty out_ready.
        for (int s = 0; s < 3; s++) begin
            int          acc, cyc;
            int unsigned rprob;
            logic [63:0] ra, rb;
            sel = s; acc = 0; cyc = 0; rprob = 4;
            while (acc < NBEATS && cyc < 20000) begin
                if (cyc % 64 == 0) rprob = $urandom_range(1, 4);
                ra = {$urandom, $urandom};
                rb = ($urandom_range(0, 7) == 0) ? ~ra : {$urandom, $urandom};
                step($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom_range(1, 4) <= rprob);
                if (last_acc) acc++;
                cyc++;
            end
            check($sformatf("rand_w%0d_beats", width_of(s)), 64'(acc), 64'(NBEATS));
            drain($sformatf("rand_w%0d", width_of(s)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
